i2c_responder: RTL and testbench



---
 rtl/i2c_responder.sv | 232 +++++++++++++++++++++++
 tb/tb_i2c_responder.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_responder.sv
// i2c_responder: I2C target that oversamples SCL/SDA on clk, detects
// START/repeated START/STOP, matches a 7-bit address and serves reads and
// writes to a byte register file through an auto-incrementing pointer.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | waiting for START; all other bus activity is ignored
// ADDR     | shifting in the 7-bit address and R/W bit
// ADDR_ACK | driving ACK for a matched address
// WR_PTR   | receiving the register pointer byte
// WR_DATA  | receiving data bytes destined for reg[ptr]
// WR_ACK   | driving ACK for a received pointer or data byte
// RD_DATA  | shifting reg[ptr] out MSB first
// RD_ACK   | sampling the master's ACK/NACK after a read byte
module i2c_responder #(
    parameter logic [6:0] TARGET_ADDR = 7'h50,
    parameter int         NUM_REGS    = 16,
    parameter int         SYNC_STAGES = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        scl_in,
    input  logic                        sda_in,
    output logic                        sda_oe,
    input  logic [$clog2(NUM_REGS)-1:0] dbg_addr,
    output logic [7:0]                  dbg_data,
    output logic                        start_det,
    output logic                        stop_det,
    output logic                        wr_strobe,
    output logic                        busy
);

    localparam int PTR_W = $clog2(NUM_REGS);

    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, WR_PTR, WR_DATA, WR_ACK, RD_DATA, RD_ACK
    } state_t;

    logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
    logic                   scl_s, sda_s, scl_p, sda_p;
    logic                   scl_rise, scl_fall, start_cond, stop_cond;

    state_t             state, state_n;
    logic [3:0]         bit_cnt, bit_cnt_n;
    logic [7:0]         rx, rx_n;
    logic [7:0]         tx, tx_n;
    logic [PTR_W-1:0]   ptr, ptr_n;
    logic               oe_n, busy_n, rw, rw_n, ack_seen, ack_seen_n;
    logic               start_n, stop_n, wr_n, reg_we;
    logic [7:0]         regs [NUM_REGS];
    logic [7:0]         rd_byte;

    // Input synchronizers plus one-cycle-delayed copies for edge detection;
    // everything resets high so an idle bus produces no spurious edges.
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_p    <= 1'b1;
            sda_p    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
            scl_p    <= scl_s;
            sda_p    <= sda_s;
        end
    end

    assign scl_s      = scl_sync[SYNC_STAGES-1];
    assign sda_s      = sda_sync[SYNC_STAGES-1];
    assign scl_rise   = scl_s & ~scl_p;
    assign scl_fall   = ~scl_s & scl_p;
    assign start_cond = ~sda_s & sda_p & scl_s;
    assign stop_cond  = sda_s & ~sda_p & scl_s;

    assign rd_byte  = regs[ptr];
    assign dbg_data = regs[dbg_addr];

    // Next-state and datapath decode; START/STOP take priority over any state.
    always_comb begin
        state_n    = state;
        bit_cnt_n  = bit_cnt;
        rx_n       = rx;
        tx_n       = tx;
        ptr_n      = ptr;
        oe_n       = sda_oe;
        busy_n     = busy;
        rw_n       = rw;
        ack_seen_n = ack_seen;
        start_n    = 1'b0;
        stop_n     = 1'b0;
        wr_n       = 1'b0;
        reg_we     = 1'b0;

        if (start_cond) begin
            state_n    = ADDR;
            bit_cnt_n  = 4'd0;
            oe_n       = 1'b0;
            ack_seen_n = 1'b0;
            start_n    = 1'b1;
        end else if (stop_cond) begin
            state_n = IDLE;
            oe_n    = 1'b0;
            busy_n  = 1'b0;
            stop_n  = 1'b1;
        end else begin
            case (state)
                IDLE: ;
                ADDR, WR_PTR, WR_DATA: begin
                    if (scl_rise && bit_cnt != 4'd8) begin
                        rx_n      = {rx[6:0], sda_s};
                        bit_cnt_n = bit_cnt + 4'd1;
                    end else if (scl_fall && bit_cnt == 4'd8) begin
                        bit_cnt_n = 4'd0;
                        if (state == ADDR) begin
                            if (rx[7:1] == TARGET_ADDR) begin
                                oe_n    = 1'b1;
                                busy_n  = 1'b1;
                                rw_n    = rx[0];
                                state_n = ADDR_ACK;
                            end else begin
                                state_n = IDLE;
                            end
                        end else if (state == WR_PTR) begin
                            ptr_n   = rx[PTR_W-1:0];
                            oe_n    = 1'b1;
                            state_n = WR_ACK;
                        end else begin
                            reg_we  = 1'b1;
                            wr_n    = 1'b1;
                            ptr_n   = ptr + PTR_W'(1);
                            oe_n    = 1'b1;
                            state_n = WR_ACK;
                        end
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall) begin
                        bit_cnt_n = 4'd0;
                        if (rw) begin
                            tx_n    = rd_byte;
                            oe_n    = ~rd_byte[7];
                            state_n = RD_DATA;
                        end else begin
                            oe_n    = 1'b0;
                            state_n = WR_PTR;
                        end
                    end
                end
                WR_ACK: begin
                    if (scl_fall) begin
                        oe_n      = 1'b0;
                        bit_cnt_n = 4'd0;
                        state_n   = WR_DATA;
                    end
                end
                RD_DATA: begin
                    if (scl_fall) begin
                        if (bit_cnt == 4'd7) begin
                            oe_n       = 1'b0;
                            ack_seen_n = 1'b0;
                            state_n    = RD_ACK;
                        end else begin
                            tx_n      = {tx[6:0], 1'b0};
                            oe_n      = ~tx[6];
                            bit_cnt_n = bit_cnt + 4'd1;
                        end
                    end
                end
                RD_ACK: begin
                    if (scl_rise) begin
                        if (sda_s) begin
                            busy_n  = 1'b0;
                            state_n = IDLE;
                        end else begin
                            ptr_n      = ptr + PTR_W'(1);
                            ack_seen_n = 1'b1;
                        end
                    end else if (scl_fall && ack_seen) begin
                        tx_n      = rd_byte;
                        oe_n      = ~rd_byte[7];
                        bit_cnt_n = 4'd0;
                        state_n   = RD_DATA;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // State register and registered outputs; sda_oe only moves on the cycle
    // after a detected SCL fall (or a START/STOP clearing it).
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            bit_cnt   <= 4'd0;
            rx        <= 8'h00;
            tx        <= 8'h00;
            ptr       <= '0;
            sda_oe    <= 1'b0;
            busy      <= 1'b0;
            rw        <= 1'b0;
            ack_seen  <= 1'b0;
            start_det <= 1'b0;
            stop_det  <= 1'b0;
            wr_strobe <= 1'b0;
        end else begin
            state     <= state_n;
            bit_cnt   <= bit_cnt_n;
            rx        <= rx_n;
            tx        <= tx_n;
            ptr       <= ptr_n;
            sda_oe    <= oe_n;
            busy      <= busy_n;
            rw        <= rw_n;
            ack_seen  <= ack_seen_n;
            start_det <= start_n;
            stop_det  <= stop_n;
            wr_strobe <= wr_n;
        end
    end

    // Register file; a data byte lands on the same edge that raises wr_strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= 8'h00;
        end else if (reg_we) begin
            regs[ptr] <= rx;
        end
    end

endmodule

// File: tb/tb_i2c_responder.sv
// tb_i2c_responder: bit-banged I2C master driving i2c_responder through a
// wired-AND SDA, with optional 8-cycle delay lines on the master's SCL/SDA.
module tb_i2c_responder;

    localparam int T = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       scl_m, sda_m, dly_en;
    logic [3:0] dbg_addr;
    logic [7:0] dbg_data;
    logic       sda_oe, start_det, stop_det, wr_strobe, busy;
    logic       scl_in_w, sda_in_w;
    logic [7:0] scl_dl = '1;
    logic [7:0] sda_dl = '1;

    int n_checks = 0;
    int n_fail   = 0;
    int n_start  = 0;
    int n_stop   = 0;
    int n_wr     = 0;
    int n_oe     = 0;

    typedef enum int {OP_START, OP_STOP, OP_WR, OP_RD} op_e;
    typedef struct {
        op_e        op;
        logic [7:0] din;
        logic       exp_ack;
        logic [7:0] exp_data;
        logic       exp_busy;
    } vec_t;
    vec_t vecs [16];

    i2c_responder #(.TARGET_ADDR(7'h50), .NUM_REGS(16), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .scl_in(scl_in_w), .sda_in(sda_in_w),
        .sda_oe(sda_oe), .dbg_addr(dbg_addr), .dbg_data(dbg_data),
        .start_det(start_det), .stop_det(stop_det),
        .wr_strobe(wr_strobe), .busy(busy)
    );

    always #5 clk = ~clk;

    // Line-delay model between master and target.
    always @(posedge clk) begin
        scl_dl <= {scl_dl[6:0], scl_m};
        sda_dl <= {sda_dl[6:0], sda_m};
    end

    assign scl_in_w = dly_en ? scl_dl[7] : scl_m;
    assign sda_in_w = (dly_en ? sda_dl[7] : sda_m) & ~sda_oe;

    // Pulse counters sampled on the falling edge.
    always @(negedge clk) begin
        if (start_det) n_start++;
        if (stop_det)  n_stop++;
        if (wr_strobe) n_wr++;
        if (sda_oe)    n_oe++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int idx,
                         input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got 0x%0h expected 0x%0h", name, idx, got, exp);
        end
    endtask

    task automatic check_reg(input int a, input logic [7:0] e);
        dbg_addr = 4'(a);
        #1;
        check("reg", a, 32'(dbg_data), 32'(e));
    endtask

    task automatic bit_out(input logic b, output logic rd);
        tick(T); sda_m = b;
        tick(T); scl_m = 1'b1;
        tick(T); rd = sda_m & ~sda_oe;
        tick(T); scl_m = 1'b0;
    endtask

    task automatic bus_start();
        tick(T); sda_m = 1'b1;
        tick(T); scl_m = 1'b1;
        tick(T); sda_m = 1'b0;
        tick(T); scl_m = 1'b0;
    endtask

    task automatic bus_stop();
        tick(T); sda_m = 1'b0;
        tick(T); scl_m = 1'b1;
        tick(T); sda_m = 1'b1;
        tick(T);
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        logic rd;
        for (int b = 7; b >= 0; b--) bit_out(d[b], rd);
        bit_out(1'b1, rd);
        ack = ~rd;
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] d);
        logic rd;
        for (int b = 7; b >= 0; b--) begin
            bit_out(1'b1, rd);
            d[b] = rd;
        end
        bit_out(nack, rd);
    endtask

    task automatic apply_vec(input int i);
        logic       ack;
        logic [7:0] d;
        case (vecs[i].op)
            OP_START: bus_start();
            OP_STOP:  bus_stop();
            OP_WR: begin
                write_byte(vecs[i].din, ack);
                check("ack", i, 32'(ack), 32'(vecs[i].exp_ack));
            end
            OP_RD: begin
                read_byte(vecs[i].din[0], d);
                check("rd_data", i, 32'(d), 32'(vecs[i].exp_data));
            end
            default: ;
        endcase
        check("busy", i, 32'(busy), 32'(vecs[i].exp_busy));
    endtask

    initial begin
        int   s_start, s_stop, s_wr, s_oe;
        logic rd, ack, got;

        // write with pointer wrap, then pointer write + Sr + 3-byte read
        vecs[0]  = '{OP_START, 8'h00, 1'b0, 8'h00, 1'b0};
        vecs[1]  = '{OP_WR,    8'hA0, 1'b1, 8'h00, 1'b1};
        vecs[2]  = '{OP_WR,    8'h0E, 1'b1, 8'h00, 1'b1};
        vecs[3]  = '{OP_WR,    8'h11, 1'b1, 8'h00, 1'b1};
        vecs[4]  = '{OP_WR,    8'h22, 1'b1, 8'h00, 1'b1};
        vecs[5]  = '{OP_WR,    8'h33, 1'b1, 8'h00, 1'b1};
        vecs[6]  = '{OP_STOP,  8'h00, 1'b0, 8'h00, 1'b0};
        vecs[7]  = '{OP_START, 8'h00, 1'b0, 8'h00, 1'b0};
        vecs[8]  = '{OP_WR,    8'hA0, 1'b1, 8'h00, 1'b1};
        vecs[9]  = '{OP_WR,    8'h0E, 1'b1, 8'h00, 1'b1};
        vecs[10] = '{OP_START, 8'h00, 1'b0, 8'h00, 1'b1};
        vecs[11] = '{OP_WR,    8'hA1, 1'b1, 8'h00, 1'b1};
        vecs[12] = '{OP_RD,    8'h00, 1'b0, 8'h11, 1'b1};
        vecs[13] = '{OP_RD,    8'h00, 1'b0, 8'h22, 1'b1};
        vecs[14] = '{OP_RD,    8'h01, 1'b0, 8'h33, 1'b0};
        vecs[15] = '{OP_STOP,  8'h00, 1'b0, 8'h00, 1'b0};

        rst = 1'b1; scl_m = 1'b1; sda_m = 1'b1; dly_en = 1'b0; dbg_addr = 4'd0;
        tick(5);
        check("rst_sda_oe", 0, 32'(sda_oe), 32'd0);
        check("rst_start_det", 0, 32'(start_det), 32'd0);
        check("rst_stop_det", 0, 32'(stop_det), 32'd0);
        check("rst_wr_strobe", 0, 32'(wr_strobe), 32'd0);
        check("rst_busy", 0, 32'(busy), 32'd0);
        for (int r = 0; r < 16; r++) check_reg(r, 8'h00);
        rst = 1'b0;
        tick(10);

        // write with wrap
        s_wr = n_wr; s_stop = n_stop;
        for (int i = 0; i < 7; i++) apply_vec(i);
        check("wr_strobes", 0, 32'(n_wr - s_wr), 32'd3);
        check("stop_pulses", 0, 32'(n_stop - s_stop), 32'd1);
        check_reg(14, 8'h11);
        check_reg(15, 8'h22);
        check_reg(0, 8'h33);
        check_reg(13, 8'h00);

        // read with repeated START
        s_start = n_start; s_stop = n_stop;
        for (int i = 7; i < 16; i++) apply_vec(i);
        check("start_pulses", 1, 32'(n_start - s_start), 32'd2);
        check("stop_pulses", 1, 32'(n_stop - s_stop), 32'd1);

        // address mismatch
        s_oe = n_oe; s_wr = n_wr;
        bus_start();
        write_byte(8'hB0, ack);
        check("mismatch_ack", 0, 32'(ack), 32'd0);
        write_byte(8'h5A, ack);
        check("mismatch_ack", 1, 32'(ack), 32'd0);
        check("mismatch_busy", 0, 32'(busy), 32'd0);
        bus_stop();
        check("mismatch_oe_cycles", 0, 32'(n_oe - s_oe), 32'd0);
        check("mismatch_wr", 0, 32'(n_wr - s_wr), 32'd0);
        check_reg(14, 8'h11);
        check_reg(0, 8'h33);

        // abort a data byte after 4 bits
        s_wr = n_wr;
        bus_start();
        write_byte(8'hA0, ack);
        check("abort_addr_ack", 0, 32'(ack), 32'd1);
        write_byte(8'h03, ack);
        check("abort_ptr_ack", 0, 32'(ack), 32'd1);
        for (int b = 0; b < 4; b++) bit_out(1'b1, rd);
        bus_stop();
        check("abort_wr", 0, 32'(n_wr - s_wr), 32'd0);
        check("abort_busy", 0, 32'(busy), 32'd0);
        check("abort_sda_oe", 0, 32'(sda_oe), 32'd0);
        check_reg(3, 8'h00);
        check("abort_ptr", 0, 32'(dut.ptr), 32'd3);

        // reset while the address ACK is being driven
        bus_start();
        for (int b = 7; b >= 0; b--) bit_out(b == 7 || b == 5, rd);
        got = 1'b0;
        for (int k = 0; k < 64 && !got; k++) begin
            tick(1);
            if (sda_oe) got = 1'b1;
        end
        check("ack_before_rst", 0, 32'(sda_oe), 32'd1);
        rst = 1'b1;
        tick(1);
        check("rst_mid_sda_oe", 0, 32'(sda_oe), 32'd0);
        check("rst_mid_busy", 0, 32'(busy), 32'd0);
        check("rst_mid_ptr", 0, 32'(dut.ptr), 32'd0);
        for (int r = 0; r < 16; r++) check_reg(r, 8'h00);
        sda_m = 1'b1;
        tick(2);
        scl_m = 1'b1;
        tick(4);
        rst = 1'b0;
        tick(10);

        // write-with-wrap again through 8-cycle line delays
        dly_en = 1'b1;
        tick(20);
        s_wr = n_wr;
        for (int i = 0; i < 7; i++) apply_vec(i);
        check("dly_wr_strobes", 0, 32'(n_wr - s_wr), 32'd3);
        check_reg(14, 8'h11);
        check_reg(15, 8'h22);
        check_reg(0, 8'h33);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
